// File: rtl/robot_motion_ctrl.sv
// rtl/robot_motion_ctrl.sv - distance-driven motion sequencer (IDLE/FWD/SLOW/STOP/TURN) with debounce, hysteresis and sensor watchdog
module robot_motion_ctrl #(
   parameter int DIST_W      = 16,
   parameter int STOP_DIST   = 20,
   parameter int SLOW_DIST   = 50,
   parameter int HYST        = 5,
   parameter int DEBOUNCE    = 3,
   parameter int STOP_HOLD   = 4,
   parameter int TURN_CYCLES = 8,
   parameter int WDOG        = 64,
   parameter int SPEED_W     = 8,
   parameter int SPEED_FAST  = 200,
   parameter int SPEED_SLOW  = 80
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               dist_valid,
   input  logic [DIST_W-1:0]  dist_v,
   output logic [SPEED_W-1:0] motor_speed,
   output logic [1:0]         motor_dir,
   output logic [2:0]         state_o,
   output logic [7:0]         obstacle_cnt,
   output logic               wdog_trip
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_FWD  = 3'd1,
      S_SLOW = 3'd2,
      S_STOP = 3'd3,
      S_TURN = 3'd4
   } state_t;

   // Thresholds are widened by one bit so SLOW_DIST+HYST cannot wrap.
   localparam logic [DIST_W:0]  STOP_THR  = (DIST_W+1)'(STOP_DIST);
   localparam logic [DIST_W:0]  SLOW_THR  = (DIST_W+1)'(SLOW_DIST);
   localparam logic [DIST_W:0]  CLEAR_THR = (DIST_W+1)'(SLOW_DIST + HYST);
   localparam logic [15:0]      DEB_LAST  = 16'(DEBOUNCE - 1);
   localparam logic [15:0]      HOLD_LAST = 16'(STOP_HOLD - 1);
   localparam logic [15:0]      TURN_LAST = 16'(TURN_CYCLES - 1);
   localparam logic [15:0]      WDOG_LAST = 16'(WDOG - 1);
   localparam logic [SPEED_W-1:0] SPD_FAST = SPEED_W'(SPEED_FAST);
   localparam logic [SPEED_W-1:0] SPD_SLOW = SPEED_W'(SPEED_SLOW);

   state_t              state, state_nx;
   logic [DIST_W-1:0]   last_dist;
   logic [15:0]         deb_cnt, deb_nx;
   logic [15:0]         tmr_cnt, tmr_nx;
   logic [15:0]         wdog_cnt, wdog_nx;
   logic                trip_nx;
   logic [SPEED_W-1:0]  speed_nx;
   logic [1:0]          dir_nx;
   logic                near, mid, clr, qualify;
   logic [DIST_W-1:0]   eval_dist;
   logic                eval_clear;

   always_comb begin
      near       = dist_valid && ({1'b0, dist_v} < STOP_THR);
      mid        = dist_valid && !near && ({1'b0, dist_v} < SLOW_THR);
      clr        = dist_valid && ({1'b0, dist_v} >= CLEAR_THR);
      // A sample arriving on the turn-expiry edge takes part in the decision.
      eval_dist  = dist_valid ? dist_v : last_dist;
      eval_clear = ({1'b0, eval_dist} >= CLEAR_THR);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      deb_nx   = deb_cnt;
      tmr_nx   = tmr_cnt;
      wdog_nx  = wdog_cnt;
      trip_nx  = 1'b0;
      qualify  = 1'b0;
      speed_nx = '0;
      dir_nx   = 2'b00;
      if (!enable) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE: state_nx = S_FWD;
            S_FWD, S_SLOW: begin
               qualify = (state == S_FWD) ? mid : clr;
               if (near) begin
                  state_nx = S_STOP;
               end else if (!dist_valid && wdog_cnt == WDOG_LAST) begin
                  state_nx = S_STOP;
                  trip_nx  = 1'b1;
               end else if (dist_valid) begin
                  wdog_nx = '0;
                  if (!qualify)                deb_nx = '0;
                  else if (deb_cnt == DEB_LAST) state_nx = (state == S_FWD) ? S_SLOW : S_FWD;
                  else                         deb_nx = deb_cnt + 16'd1;
               end else begin
                  wdog_nx = wdog_cnt + 16'd1;
               end
            end
            S_STOP: begin
               if (tmr_cnt == HOLD_LAST) state_nx = S_TURN;
               else                      tmr_nx   = tmr_cnt + 16'd1;
            end
            S_TURN: begin
               if (tmr_cnt != TURN_LAST) tmr_nx   = tmr_cnt + 16'd1;
               else if (eval_clear)      state_nx = S_FWD;
               else                      tmr_nx   = '0;
            end
            default: state_nx = S_IDLE;
         endcase
      end
      // Every state change, including a forced IDLE, starts the counters fresh.
      if (!enable || state_nx != state) begin
         deb_nx  = '0;
         tmr_nx  = '0;
         wdog_nx = '0;
      end
      case (state_nx)
         S_FWD:   begin speed_nx = SPD_FAST; dir_nx = 2'b01; end
         S_SLOW:  begin speed_nx = SPD_SLOW; dir_nx = 2'b01; end
         S_TURN:  begin speed_nx = SPD_SLOW; dir_nx = 2'b10; end
         default: begin speed_nx = '0;       dir_nx = 2'b00; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         deb_cnt      <= '0;
         tmr_cnt      <= '0;
         wdog_cnt     <= '0;
         last_dist    <= '0;
         obstacle_cnt <= '0;
         wdog_trip    <= 1'b0;
         motor_speed  <= '0;
         motor_dir    <= 2'b00;
      end else begin
         deb_cnt     <= deb_nx;
         tmr_cnt     <= tmr_nx;
         wdog_cnt    <= wdog_nx;
         wdog_trip   <= trip_nx;
         motor_speed <= speed_nx;
         motor_dir   <= dir_nx;
         if (dist_valid)
            last_dist <= dist_v;
         if (state_nx == S_STOP && state != S_STOP && obstacle_cnt != 8'hFF)
            obstacle_cnt <= obstacle_cnt + 8'd1;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_robot_motion_ctrl.sv
// tb/tb_robot_motion_ctrl.sv - directed and randomized checks of robot_motion_ctrl against a behavioural model
module tb_robot_motion_ctrl;

   localparam int STOP_DIST   = 20;
   localparam int SLOW_DIST   = 50;
   localparam int HYST        = 5;
   localparam int DEBOUNCE    = 3;
   localparam int STOP_HOLD   = 4;
   localparam int TURN_CYCLES = 8;
   localparam int WDOG        = 64;

   localparam int M_IDLE = 0, M_FWD = 1, M_SLOW = 2, M_STOP = 3, M_TURN = 4;
   localparam int Z_NEAR = 0, Z_MID = 1, Z_BAND = 2, Z_CLEAR = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        dist_valid = 1'b0;
   logic [15:0] dist_v = '0;
   logic [7:0]  motor_speed;
   logic [1:0]  motor_dir;
   logic [2:0]  state_o;
   logic [7:0]  obstacle_cnt;
   logic        wdog_trip;

   int checks = 0;
   int errors = 0;

   int m_mode, m_run, m_dwell, m_quiet, m_last, m_obs, m_trip;

   robot_motion_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .dist_valid   (dist_valid),
      .dist_v       (dist_v),
      .motor_speed  (motor_speed),
      .motor_dir    (motor_dir),
      .state_o      (state_o),
      .obstacle_cnt (obstacle_cnt),
      .wdog_trip    (wdog_trip)
   );

   always #5 clk = ~clk;

   function automatic int zone(input int d);
      if (d < STOP_DIST)        return Z_NEAR;
      if (d < SLOW_DIST)        return Z_MID;
      if (d < SLOW_DIST + HYST) return Z_BAND;
      return Z_CLEAR;
   endfunction

   function automatic int exp_speed(input int mode);
      if (mode == M_FWD) return 200;
      if (mode == M_SLOW || mode == M_TURN) return 80;
      return 0;
   endfunction

   function automatic int exp_dir(input int mode);
      if (mode == M_FWD || mode == M_SLOW) return 1;
      if (mode == M_TURN) return 2;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Behavioural model: one call per clock edge, using the inputs held for that edge.
   task automatic model_edge(input logic r, input logic en, input logic v, input int d);
      int nm, dwell_n, newlast;
      if (r) begin
         m_mode = M_IDLE; m_run = 0; m_dwell = 0; m_quiet = 0;
         m_last = 0; m_obs = 0; m_trip = 0;
         return;
      end
      nm      = m_mode;
      m_trip  = 0;
      newlast = v ? d : m_last;
      dwell_n = m_dwell + 1;
      if (!en) begin
         nm = M_IDLE;
      end else begin
         case (m_mode)
            M_IDLE: nm = M_FWD;
            M_FWD, M_SLOW: begin
               if (v && zone(d) == Z_NEAR) nm = M_STOP;
               else if (!v && m_quiet + 1 >= WDOG) begin
                  nm = M_STOP;
                  m_trip = 1;
               end else if (v) begin
                  if (zone(d) == ((m_mode == M_FWD) ? Z_MID : Z_CLEAR)) begin
                     m_run++;
                     if (m_run >= DEBOUNCE) nm = (m_mode == M_FWD) ? M_SLOW : M_FWD;
                  end else begin
                     m_run = 0;
                  end
               end
            end
            M_STOP: if (dwell_n >= STOP_HOLD) nm = M_TURN;
            M_TURN: if (dwell_n >= TURN_CYCLES) begin
               if (zone(newlast) == Z_CLEAR) nm = M_FWD;
               else dwell_n = 0;
            end
            default: nm = M_IDLE;
         endcase
      end
      m_quiet = v ? 0 : m_quiet + 1;
      m_dwell = dwell_n;
      if (nm == M_STOP && m_mode != M_STOP && m_obs < 255) m_obs++;
      if (!en || nm != m_mode) begin
         m_run = 0; m_dwell = 0; m_quiet = 0;
      end
      m_last = newlast;
      m_mode = nm;
   endtask

   task automatic step(input logic r, input logic en, input logic v, input int d);
      rst        = r;
      enable     = en;
      dist_valid = v;
      dist_v     = 16'(d);
      model_edge(r, en, v, d);
      @(posedge clk);
      #1;
      chk("model_state", 32'(state_o), 32'(m_mode));
      chk("model_speed", 32'(motor_speed), 32'(exp_speed(m_mode)));
      chk("model_dir", 32'(motor_dir), 32'(exp_dir(m_mode)));
      chk("model_obs", 32'(obstacle_cnt), 32'(m_obs));
      chk("model_trip", 32'(wdog_trip), 32'(m_trip));
   endtask

   initial begin
      int d, vprob;
      @(posedge clk);
      #1;

      // reset and start
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("rst_state", 32'(state_o), 0);
      chk("rst_speed", 32'(motor_speed), 0);
      chk("rst_dir", 32'(motor_dir), 0);
      chk("rst_obs", 32'(obstacle_cnt), 0);
      chk("rst_trip", 32'(wdog_trip), 0);
      step(0, 1, 0, 0);
      chk("start_state", 32'(state_o), 1);
      chk("start_speed", 32'(motor_speed), 200);
      chk("start_dir", 32'(motor_dir), 1);

      // debounce
      step(0, 1, 1, 30); step(0, 1, 1, 30); step(0, 1, 1, 60);
      chk("deb_broken", 32'(state_o), 1);
      step(0, 1, 1, 30); step(0, 1, 1, 30);
      chk("deb_two", 32'(state_o), 1);
      step(0, 1, 1, 30);
      chk("deb_slow_state", 32'(state_o), 2);
      chk("deb_slow_speed", 32'(motor_speed), 80);

      // hysteresis
      repeat (3) step(0, 1, 1, 52);
      chk("hyst_band", 32'(state_o), 2);
      step(0, 1, 1, 55); step(0, 1, 1, 55);
      chk("hyst_two", 32'(state_o), 2);
      step(0, 1, 1, 55);
      chk("hyst_fwd", 32'(state_o), 1);

      // obstacle, stop hold, turn retry, turn exit
      step(0, 1, 1, 10);
      chk("near_state", 32'(state_o), 3);
      chk("near_speed", 32'(motor_speed), 0);
      chk("near_obs", 32'(obstacle_cnt), 1);
      repeat (3) step(0, 1, 0, 0);
      chk("stop_hold", 32'(state_o), 3);
      step(0, 1, 0, 0);
      chk("turn_enter", 32'(state_o), 4);
      chk("turn_dir", 32'(motor_dir), 2);
      repeat (7) step(0, 1, 0, 0);
      chk("turn_first", 32'(state_o), 4);
      step(0, 1, 0, 0);
      chk("turn_restart", 32'(state_o), 4);
      chk("turn_obs", 32'(obstacle_cnt), 1);
      repeat (6) step(0, 1, 0, 0);
      step(0, 1, 1, 100);
      chk("turn_second", 32'(state_o), 4);
      step(0, 1, 0, 0);
      chk("turn_exit", 32'(state_o), 1);

      // watchdog trip
      repeat (63) step(0, 1, 0, 0);
      chk("wdog_edge", 32'(state_o), 1);
      step(0, 1, 0, 0);
      chk("wdog_state", 32'(state_o), 3);
      chk("wdog_trip", 32'(wdog_trip), 1);
      chk("wdog_obs", 32'(obstacle_cnt), 2);
      step(0, 1, 0, 0);
      chk("wdog_pulse", 32'(wdog_trip), 0);
      repeat (11) step(0, 1, 0, 0);
      chk("wdog_recover", 32'(state_o), 1);

      // watchdog rescued by a sample on the trip cycle
      repeat (63) step(0, 1, 0, 0);
      step(0, 1, 1, 100);
      chk("wdog_save_state", 32'(state_o), 1);
      chk("wdog_save_trip", 32'(wdog_trip), 0);
      step(0, 1, 0, 0);
      chk("wdog_save_after", 32'(state_o), 1);

      // enable drop and reset in TURN
      step(0, 1, 1, 10);
      repeat (4) step(0, 1, 0, 0);
      chk("en_pre_turn", 32'(state_o), 4);
      step(0, 0, 0, 0);
      chk("en_idle", 32'(state_o), 0);
      chk("en_obs", 32'(obstacle_cnt), 3);
      step(0, 1, 0, 0);
      step(0, 1, 1, 10);
      repeat (4) step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      chk("rst_turn_state", 32'(state_o), 0);
      chk("rst_turn_speed", 32'(motor_speed), 0);
      chk("rst_turn_dir", 32'(motor_dir), 0);
      chk("rst_turn_obs", 32'(obstacle_cnt), 0);

      // obstacle counter saturation
      step(0, 1, 0, 0);
      for (int i = 0; i < 260; i++) begin
         step(0, 1, 1, 10);
         step(0, 0, 0, 0);
         step(0, 1, 0, 0);
      end
      chk("obs_saturate", 32'(obstacle_cnt), 255);

      // randomized phases against the model
      step(1, 0, 0, 0);
      for (int blk = 0; blk < 30; blk++) begin
         vprob = (blk % 3 == 0) ? 1 : ((blk % 3 == 1) ? 30 : 80);
         for (int c = 0; c < 100; c++) begin
            case ($urandom_range(0, 7))
               0:       d = $urandom_range(0, 19);
               1, 2:    d = $urandom_range(20, 49);
               3:       d = $urandom_range(50, 54);
               4, 5:    d = $urandom_range(55, 300);
               6:       d = 65535;
               default: d = 19 + 31 * $urandom_range(0, 1) + $urandom_range(0, 5);
            endcase
            step(($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < vprob) ? 1'b1 : 1'b0,
                 d);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
